// File: rtl/demux1to4_stream.sv
// -----------------------------------------------------------------------------
// demux1to4_stream
//
// Purpose:
//   Registered 1-to-4 stream demultiplexer. One W-bit valid/ready input stream
//   is steered into one of four output holding registers. Each output has its
//   own valid/ready handshake. Latency is one cycle. No word is lost, and none
//   is duplicated, under backpressure.
//
// Optional feature (compile-time macro DEMUX_AUTO_SEL_EN):
//   When defined, a 2-bit round-robin pointer replaces the s input as the
//   destination index. The pointer advances on every accepted word. When the
//   pointed-at channel is full and not ready, the block stalls; it never skips
//   ahead to another channel.
//   When undefined, each accepted word is routed to the channel given by s.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   s          in   2   destination select (sampled on accept; unused in auto mode)
//   in_data    in   W   input word
//   in_valid   in   1   input word present
//   in_ready   out  1   block can accept in_data this cycle (combinational)
//   f0..f3     out  W   channel holding registers
//   out_valid  out  4   bit k set: fk holds an undelivered word
//   out_ready  in   4   bit k set: consumer k takes fk this cycle
//   acc_cnt    out  8   total accepted words, modulo 256
// -----------------------------------------------------------------------------
module demux1to4_stream #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   s,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] f0,
    output logic [W-1:0] f1,
    output logic [W-1:0] f2,
    output logic [W-1:0] f3,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [7:0]   acc_cnt
);

    logic [1:0]   dst;          // destination channel for this cycle
    logic         accept;       // input handshake completes this cycle
    logic [W-1:0] f_all [4];    // per-channel holding registers, gathered
    logic [3:0]   valid_all;    // per-channel FULL flags, gathered
    logic [7:0]   acc_cnt_q;
    logic [7:0]   acc_cnt_d;

`ifdef DEMUX_AUTO_SEL_EN
    logic [1:0] ptr_q;
    logic [1:0] ptr_d;
    logic       unused_s;

    // s has no role when the pointer steers the data.
    assign unused_s = ^s;
    assign dst      = ptr_q;

    // The pointer only moves when a word is actually taken, so a stalled
    // channel keeps the pointer parked on it (no skipping).
    always_comb begin
        ptr_d = ptr_q + {1'b0, accept};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign dst = s;
`endif

    // A full destination can still take a new word in the same cycle that its
    // consumer drains the old one, which gives full throughput on one channel.
    assign in_ready = ~valid_all[dst] | out_ready[dst];
    assign accept   = in_valid & in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            logic         load;
            logic [W-1:0] f_q;
            logic [W-1:0] f_d;
            logic         valid_q;
            logic         valid_d;

            assign load = accept & (dst == 2'(gi));

            // A load wins over a drain: the old word leaves on out_ready while
            // the new word arrives, and valid stays set.
            always_comb begin
                f_d     = f_q;
                valid_d = valid_q & ~out_ready[gi];
                if (load) begin
                    f_d     = in_data;
                    valid_d = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    f_q     <= '0;
                    valid_q <= 1'b0;
                end else begin
                    f_q     <= f_d;
                    valid_q <= valid_d;
                end
            end

            assign f_all[gi]     = f_q;
            assign valid_all[gi] = valid_q;
        end
    endgenerate

    always_comb begin
        acc_cnt_d = acc_cnt_q + {7'd0, accept};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_q <= 8'd0;
        end else begin
            acc_cnt_q <= acc_cnt_d;
        end
    end

    assign f0        = f_all[0];
    assign f1        = f_all[1];
    assign f2        = f_all[2];
    assign f3        = f_all[3];
    assign out_valid = valid_all;
    assign acc_cnt   = acc_cnt_q;

endmodule

// File: tb/tb_demux1to4_stream.sv
// -----------------------------------------------------------------------------
// tb_demux1to4_stream
//
// Self-checking bench for demux1to4_stream (W = 3). Covers the idle state after
// reset, asynchronous reset in mid-cycle, a table of directed vectors (manual
// mode) or a round-robin sequence (when DEMUX_AUTO_SEL_EN is defined), the
// 8-bit counter wrap, and a randomized run. The randomized run is checked
// against a per-channel queue scoreboard of undelivered words.
// -----------------------------------------------------------------------------
module tb_demux1to4_stream;

    localparam int W = 3;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic [1:0]   s         = 2'd0;
    logic [W-1:0] in_data   = '0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] f0, f1, f2, f3;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready = 4'b0000;
    logic [7:0]   acc_cnt;

    int n_vec = 0;
    int n_err = 0;

    demux1to4_stream #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s         (s),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .f0        (f0),
        .f1        (f1),
        .f2        (f2),
        .f3        (f3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_cnt   (acc_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] get_f(input int k);
        case (k)
            0:       return f0;
            1:       return f1;
            2:       return f2;
            default: return f3;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [1:0] sel, input logic [W-1:0] d,
                         input logic [3:0] r);
        in_valid  = v;
        s         = sel;
        in_data   = d;
        out_ready = r;
    endtask

    // Advance one clock; registered outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 2'd0, '0, 4'b0000);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // Directed vectors: inputs applied for one cycle, then the state after
    // that cycle's edge is compared.
    typedef struct {
        logic         v;
        logic [1:0]   sel;
        logic [W-1:0] d;
        logic [3:0]   r;
        logic         exp_ir;
        logic [3:0]   exp_ov;
        int           exp_ch;
        logic [W-1:0] exp_f;
        int           exp_acc;
    } vec_t;

    // Scoreboard: words accepted but not yet delivered, per channel.
    logic [W-1:0] mq [4][$];
    logic [W-1:0] mlast [4];
    int           mcnt;
    int           mptr;

    initial begin
        vec_t tbl [9];
        logic [W-1:0] held;
        logic [7:0]   acc_before;
        int           dd;
        logic         exp_ir;

        // ---------------- reset and idle state ----------------
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        chk("idle_out_valid", out_valid, 4'b0000);
        chk("idle_f0", f0, 0);
        chk("idle_f1", f1, 0);
        chk("idle_f2", f2, 0);
        chk("idle_f3", f3, 0);
        chk("idle_acc_cnt", acc_cnt, 0);
        chk("idle_in_ready", in_ready, 1);
        $display("reset: out_valid=%b acc_cnt=%0d in_ready=%b", out_valid, acc_cnt, in_ready);

        // ---------------- asynchronous reset mid-cycle ----------------
        drive(1'b1, 2'd1, 3'd5, 4'b0000);
        step();
        drive(1'b1, 2'd3, 3'd6, 4'b0000);
        step();
        drive(1'b0, 2'd0, '0, 4'b0000);
`ifdef DEMUX_AUTO_SEL_EN
        chk("prerst_out_valid", out_valid, 4'b0011);
`else
        chk("prerst_out_valid", out_valid, 4'b1010);
`endif
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 4'b0000);
        chk("async_rst_f1", f1, 0);
        chk("async_rst_f3", f3, 0);
        chk("async_rst_acc", acc_cnt, 0);
        chk("async_rst_in_ready", in_ready, 1);
        $display("async reset: out_valid=%b f1=%0d f3=%0d", out_valid, f1, f3);
        @(negedge clk);
        rst_n = 1'b1;
        step();

`ifndef DEMUX_AUTO_SEL_EN
        // ---------------- manual mode directed table ----------------
        tbl[0] = '{1'b1, 2'd0, 3'd1, 4'b1111, 1'b1, 4'b0001, 0, 3'd1, 1};
        tbl[1] = '{1'b1, 2'd1, 3'd2, 4'b1111, 1'b1, 4'b0010, 1, 3'd2, 2};
        tbl[2] = '{1'b1, 2'd2, 3'd3, 4'b1111, 1'b1, 4'b0100, 2, 3'd3, 3};
        tbl[3] = '{1'b1, 2'd3, 3'd4, 4'b1111, 1'b1, 4'b1000, 3, 3'd4, 4};
        tbl[4] = '{1'b0, 2'd0, 3'd0, 4'b1111, 1'b1, 4'b0000, 3, 3'd4, 4};
        tbl[5] = '{1'b1, 2'd2, 3'd5, 4'b1011, 1'b1, 4'b0100, 2, 3'd5, 5};
        tbl[6] = '{1'b1, 2'd2, 3'd6, 4'b1011, 1'b0, 4'b0100, 2, 3'd5, 5};
        tbl[7] = '{1'b1, 2'd2, 3'd6, 4'b1111, 1'b1, 4'b0100, 2, 3'd6, 6};
        tbl[8] = '{1'b0, 2'd2, 3'd0, 4'b1111, 1'b1, 4'b0000, 2, 3'd6, 6};
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].r);
            #1;
            chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].exp_ir);
            step();
            chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].exp_ov);
            chk($sformatf("vec%0d_f%0d", i, tbl[i].exp_ch), get_f(tbl[i].exp_ch), tbl[i].exp_f);
            chk($sformatf("vec%0d_acc_cnt", i), acc_cnt, tbl[i].exp_acc);
            $display("vec%0d: v=%b s=%0d d=%0d r=%b -> out_valid=%b acc_cnt=%0d",
                     i, tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].r, out_valid, acc_cnt);
        end
`else
        // ---------------- auto mode round-robin, s held at 3 ----------------
        begin
            logic [W-1:0] seq [5];
            seq[0] = 3'd7; seq[1] = 3'd1; seq[2] = 3'd2; seq[3] = 3'd3; seq[4] = 3'd4;
            for (int i = 0; i < 5; i++) begin
                drive(1'b1, 2'd3, seq[i], 4'b1111);
                step();
                chk($sformatf("rr%0d_f%0d", i, i % 4), get_f(i % 4), seq[i]);
                chk($sformatf("rr%0d_out_valid", i), out_valid, 4'b0001 << (i % 4));
                $display("rr%0d: data=%0d -> f%0d out_valid=%b", i, seq[i], i % 4, out_valid);
            end
        end
        // Pointer is now at channel 1. Block channel 1 and fill channels 1,2,3,0.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd3, 3'(i + 1), 4'b1101);
            step();
        end
        chk("blk_f1", f1, 1);
        acc_before = acc_cnt;
        drive(1'b1, 2'd3, 3'd6, 4'b1101);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("blk%0d_in_ready", i), in_ready, 0);
            step();
            chk($sformatf("blk%0d_f1", i), f1, 1);
            chk($sformatf("blk%0d_acc", i), acc_cnt, acc_before);
            $display("blocked cycle %0d: in_ready=%b out_valid=%b", i, in_ready, out_valid);
        end
        drive(1'b1, 2'd3, 3'd6, 4'b1111);
        #1;
        chk("unblk_in_ready", in_ready, 1);
        step();
        chk("unblk_f1", f1, 6);
        chk("unblk_acc", acc_cnt, 8'(acc_before + 8'd1));
        $display("unblocked: f1=%0d acc_cnt=%0d", f1, acc_cnt);
`endif

        // ---------------- 256-word counter wrap ----------------
        do_reset();
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 2'(i), 3'(i), 4'b1111);
            step();
            if (i == 254) chk("wrap_acc_255", acc_cnt, 255);
        end
        chk("wrap_acc_0", acc_cnt, 0);
        $display("wrap: acc_cnt after 256 words = %0d", acc_cnt);

        // ---------------- randomized run against the scoreboard ----------------
        do_reset();
        for (int k = 0; k < 4; k++) begin
            mq[k].delete();
            mlast[k] = '0;
        end
        mcnt = 0;
        mptr = 0;
        for (int c = 0; c < 600; c++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  W'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            #1;
`ifdef DEMUX_AUTO_SEL_EN
            dd = mptr;
`else
            dd = int'(s);
`endif
            exp_ir = (mq[dd].size() == 0) || out_ready[dd];
            chk($sformatf("rnd%0d_in_ready", c), in_ready, exp_ir);
            chk($sformatf("rnd%0d_acc", c), acc_cnt, mcnt % 256);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("rnd%0d_valid%0d", c, k), out_valid[k], mq[k].size() != 0);
                held = (mq[k].size() != 0) ? mq[k][0] : mlast[k];
                chk($sformatf("rnd%0d_f%0d", c, k), get_f(k), held);
            end
            // Deliveries first, then the accept into the destination.
            for (int k = 0; k < 4; k++) begin
                if (mq[k].size() != 0 && out_ready[k]) void'(mq[k].pop_front());
            end
            if (in_valid && exp_ir) begin
                mq[dd].push_back(in_data);
                mlast[dd] = in_data;
                mcnt++;
                mptr = (mptr + 1) % 4;
                $display("rnd%0d: accept %0d -> ch%0d (acc=%0d)", c, in_data, dd, mcnt % 256);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
